// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor main control FSM: sequences ALU, unified memory port and register file.
// Optional MC_FSM_WAIT_EN: memory states stall until mem_ready; otherwise mem_ready is ignored.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic               illegal,
  output logic [STATE_W-1:0] fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_mem_done;
  logic   w_unused;

`ifdef MC_FSM_WAIT_EN
  assign w_mem_done = mem_ready;
  assign w_unused   = &{1'b0, Funct[4:1]};
`else
  assign w_mem_done = 1'b1;
  assign w_unused   = &{1'b0, Funct[4:1], mem_ready};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (w_mem_done) begin
          IRWrite = 1'b1;
          NextPC  = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (w_mem_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        // MemW stays high through every stalled cycle of the store
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (w_mem_done) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUOp  = 1'b1;
        w_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegW   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Held in reset: strobes off, selects parked at their FETCH values
    if (!reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      illegal   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b1;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end
  end

  assign fsm_state = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: per-instruction cycle scripts built from the state/output table.
module tb_multicycle_ctrl_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, ALUOp, illegal;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] fsm_state;

  int n_checks = 0;
  int n_fail = 0;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .illegal(illegal), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  logic [12:0] w_outs;
  assign w_outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                   RegW, MemW, Branch, ALUOp, illegal};

  typedef struct {
    int          st;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic [12:0] ex;
  } rec_t;

  rec_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output vector for one cycle, straight from the state/output table
  function automatic logic [12:0] exp_out(input int st, input logic done, input logic [1:0] op);
    logic irw, npc, adr, asa, rw, mw, br, aop, ill;
    logic [1:0] asb, rs;
    {irw, npc, adr, asa, rw, mw, br, aop, ill} = '0;
    asb = 2'b00;
    rs  = 2'b00;
    case (st)
      0: begin asa = 1; asb = 2'b10; rs = 2'b10; irw = done; npc = done; end
      1: begin asa = 1; asb = 2'b10; rs = 2'b10; ill = (op == 2'b11); end
      2: asb = 2'b01;
      3: adr = 1;
      4: begin rs = 2'b01; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: aop = 1;
      7: begin asb = 2'b01; aop = 1; end
      8: rw = 1;
      9: begin asb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    return {irw, npc, adr, asa, asb, rs, rw, mw, br, aop, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Op/Funct only matter in DECODE and MEMADR, so other cycles get noise
  function automatic void push(input int st, input logic [1:0] op, input logic [5:0] f,
                               input logic mr, input logic done);
    rec_t r;
    r.st = st;
    r.mr = mr;
    if (st == 1 || st == 2) begin
      r.op = op;
      r.funct = f;
    end else begin
      r.op = 2'($urandom);
      r.funct = 6'($urandom);
    end
    r.ex = exp_out(st, done, op);
    q.push_back(r);
  endfunction

  function automatic logic done_mr();
`ifdef MC_FSM_WAIT_EN
    return 1'b1;
`else
    return rbit();
`endif
  endfunction

  function automatic void add_instr(input logic [1:0] op, input logic [5:0] f,
                                    input int wf, input int wm);
    int nwf, nwm;
`ifdef MC_FSM_WAIT_EN
    nwf = wf;
    nwm = wm;
`else
    nwf = 0;
    nwm = 0;
`endif
    for (int i = 0; i < nwf; i++) push(0, op, f, 1'b0, 1'b0);
    push(0, op, f, done_mr(), 1'b1);
    push(1, op, f, rbit(), 1'b0);
    case (op)
      2'b00: begin
        push(f[5] ? 7 : 6, op, f, rbit(), 1'b0);
        push(8, op, f, rbit(), 1'b0);
      end
      2'b01: begin
        push(2, op, f, rbit(), 1'b0);
        if (f[0]) begin
          for (int i = 0; i < nwm; i++) push(3, op, f, 1'b0, 1'b0);
          push(3, op, f, done_mr(), 1'b0);
          push(4, op, f, rbit(), 1'b0);
        end else begin
          for (int i = 0; i < nwm; i++) push(5, op, f, 1'b0, 1'b0);
          push(5, op, f, done_mr(), 1'b0);
        end
      end
      2'b10: push(9, op, f, rbit(), 1'b0);
      default: ;
    endcase
  endfunction

  task automatic drive(input rec_t r);
    Op = r.op;
    Funct = r.funct;
    mem_ready = r.mr;
  endtask

  task automatic run_queue(input string tag);
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      drive(r);
      @(negedge clk);
      check({tag, "_state"}, 32'(fsm_state), 32'(r.st));
      check({tag, "_outs"}, 32'(w_outs), 32'(r.ex));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rec_t r;
    logic [12:0] park;
    park = exp_out(0, 1'b0, 2'b00);

    // Reset held while mem_ready toggles
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      Op = 2'($urandom);
      @(negedge clk);
      check("rst_state", 32'(fsm_state), 32'd0);
      check("rst_outs", 32'(w_outs), 32'(park));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    add_instr(2'b00, 6'b001000, 0, 0);
    run_queue("add");
    add_instr(2'b01, 6'b011001, 0, 0);
    run_queue("ldr");
    add_instr(2'b01, 6'b011000, 0, 2);
    run_queue("str_wait");
    add_instr(2'b10, 6'($urandom), 0, 0);
    run_queue("branch");
    add_instr(2'b11, 6'($urandom), 0, 0);
    run_queue("illegal");
    add_instr(2'b00, 6'b100000, 1, 0);
    run_queue("addi_fwait");

    // Abort an LDR while it sits in MEMREAD
    add_instr(2'b01, 6'b000001, 0, 1);
    while (q.size() > 0) begin
      r = q.pop_front();
      drive(r);
      if (r.st == 3) begin
        #2 reset = 1'b0;
        #1;
        check("midrst_state", 32'(fsm_state), 32'd0);
        check("midrst_outs", 32'(w_outs), 32'(park));
        break;
      end
      @(negedge clk);
      check("midrst_pre_state", 32'(fsm_state), 32'(r.st));
      check("midrst_pre_outs", 32'(w_outs), 32'(r.ex));
      @(posedge clk);
      #1;
    end
    q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = rbit();
      @(negedge clk);
      check("midrst_hold_state", 32'(fsm_state), 32'd0);
      check("midrst_hold_outs", 32'(w_outs), 32'(park));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    for (int n = 0; n < 150; n++) begin
      logic [1:0] op;
      op = 2'($urandom);
      add_instr(op, 6'($urandom),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0);
      run_queue("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

- Main control state machine for the multicycle build of the processor.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction.
- Takes the instruction fields that the single-cycle decoder consumes (Op, Funct) and drives per-state datapath select and enable signals.
- The existing ALU decoder and condition logic sit downstream and consume ALUOp, RegW, MemW and Branch.

## Interface

Parameters:
- STATE_W, 4, width of the debug state output; must be ≥4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction bits [27:26], sampled from the instruction register.
- Funct  in  6  instruction bits [25:20], sampled from the instruction register.
- mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  write PC+4 into the PC.
- AdrSrc  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- ALUSrcA  out  1  ALU operand A mux: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU operand B mux: 00 = Rm, 01 = extended immediate, 10 = constant 4.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
- RegW  out  1  register write request, before condition gating.
- MemW  out  1  memory write request, before condition gating.
- Branch  out  1  branch request, before condition gating.
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = ADD.
- illegal  out  1  one-cycle pulse when an unimplemented Op is decoded.
- fsm_state  out  STATE_W  current state encoding, for debug.

## Operation

State encodings are fixed: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 are unreachable and return to FETCH.

State transitions:
- FETCH → DECODE when the fetch completes (see Configuration).
- DECODE, by Op:
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00 with Funct[5]=0 → EXECUTER.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH, with `illegal`=1 for that one cycle.
- MEMADR → MEMREAD if Funct[0]=1 (LDR), otherwise → MEMWRITE (STR).
- MEMREAD → MEMWB when the read completes.
- MEMWRITE → FETCH when the write completes.
- EXECUTER and EXECUTEI → ALUWB.
- MEMWB, ALUWB and BRANCH → FETCH.

Outputs are Moore, decoded from the state only, except for the mem_ready gating noted below. Every output not listed for a state is 0.

| State | Outputs |
|---|---|
| FETCH | AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=1 and NextPC=1 only in the completing cycle |
| DECODE | ALUSrcA=1, ALUSrcB=10, ResultSrc=10 |
| MEMADR | ALUSrcA=0, ALUSrcB=01 |
| MEMREAD | AdrSrc=1, ResultSrc=00 |
| MEMWB | ResultSrc=01, RegW=1 |
| MEMWRITE | AdrSrc=1, ResultSrc=00, MemW=1 for every cycle spent in the state |
| EXECUTER | ALUSrcA=0, ALUSrcB=00, ALUOp=1 |
| EXECUTEI | ALUSrcA=0, ALUSrcB=01, ALUOp=1 |
| ALUWB | ResultSrc=00, RegW=1 |
| BRANCH | ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1 |

Additional rules:
- Op and Funct are used only in DECODE and MEMADR; their values in other states are don't-care.
- Destination R15 writes and condition gating are handled outside this block.

## Timing

- Reset:
  - reset=0 forces state FETCH asynchronously.
  - While reset=0, IRWrite, NextPC, RegW, MemW, Branch and illegal are 0; the select outputs hold their FETCH values; fsm_state=0.
  - On the first rising edge after reset=1, FETCH behaves normally.
- Zero-wait cycle counts per instruction:
  - Data-processing: 4 (FETCH, DECODE, EXECUTE*, ALUWB).
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Unimplemented Op: 2.
- Wait states:
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - No outputs change during a wait, except that IRWrite and NextPC stay 0.
- Reset asserted mid-instruction aborts it immediately. A MemW or RegW pulse already issued is not undone; no further strobe is issued.

## Configuration

- MC_FSM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE each complete only in a cycle with mem_ready=1.
  - MEMWRITE holds MemW=1 until that cycle.
- MC_FSM_WAIT_EN undefined:
  - mem_ready is ignored (treated as 1).
  - Each memory state lasts exactly one cycle; FETCH always asserts IRWrite=1 and NextPC=1.

## Test plan

- Reset: hold reset=0 for 3 cycles while toggling mem_ready → fsm_state=0 and all strobes 0. Release → the first cycle shows IRWrite=1 and NextPC=1, with mem_ready=1.
- ADD register: Op=00, Funct=001000 → states 0,1,6,8,0. ALUOp=1 in state 6; RegW=1 only in state 8; ALUSrcB=00 in state 6.
- LDR immediate: Op=01, Funct=011001 → states 0,1,2,3,4,0. AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4.
- STR with two wait cycles (MC_FSM_WAIT_EN defined): Op=01, Funct=011000, mem_ready low for 2 cycles in state 5 → MemW=1 for 3 consecutive cycles, then FETCH.
- Branch, then illegal: Op=10 → states 0,1,9,0 with Branch=1 only in state 9. Then Op=11 → DECODE pulses illegal=1 and returns to FETCH after 2 cycles total.
- Mid-instruction reset: assert reset=0 asynchronously in state 3 → fsm_state=0 within the same cycle, and RegW is never asserted.
